dac_sample_scheduler: RTL and testbench
=======================================

DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 10, meaning the width of the DAC code.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries; a power of 2, at least 2.
REQ-003 SHALL have parameter PRIME_LEVEL, default 4, meaning the occupancy needed to start playback; 1..DEPTH.
REQ-004 SHALL have parameter IDLE_CODE, default 0, meaning the code driven when not playing.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: run playback.
REQ-008 SHALL have port mute, input, 1 bit: force code to 0 without stopping consumption.
REQ-009 SHALL have port in_sample, input, CODE_WIDTH bits: producer sample.
REQ-010 SHALL have port in_valid, input, 1 bit: producer offers in_sample.
REQ-011 SHALL have port in_ready, output, 1 bit: scheduler can accept a sample.
REQ-012 SHALL have port next_sample, input, 1 bit: DAC pulse, high in the last cycle of each PWM window.
REQ-013 SHALL have port code, output, CODE_WIDTH bits: registered code to the DAC.
REQ-014 SHALL have port fill_level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-015 SHALL have port underrun_count, output, 16 bits: saturating count of underrun events.
REQ-016 SHALL have port state_o, output, 2 bits: current FSM state encoding.

Function
REQ-017 SHALL accept a write when in_valid and in_ready are both high at posedge; in_ready SHALL equal !full, combinationally from registered occupancy.
REQ-018 SHALL NOT accept a write when full, even if a pop occurs in the same cycle.
REQ-019 SHALL NOT bypass: a sample written in cycle N is poppable no earlier than cycle N+1.
REQ-020 SHALL, on simultaneous write and pop, leave fill_level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-021 SHALL implement the FSM states IDLE=0, PRIME=1, PLAY=2, UNDERRUN=3.
REQ-022 SHALL, in IDLE: drive code=IDLE_CODE, perform no pops, accept writes, and go to PRIME when enable=1.
REQ-023 SHALL, in PRIME: hold code, perform no pops, and go to PLAY when fill_level>=PRIME_LEVEL.
REQ-024 SHALL, in PLAY with next_sample=1 and FIFO non-empty: pop the head and register it into code at that posedge, so the new window starts with the new code.
REQ-025 SHALL, in PLAY with next_sample=1 and FIFO empty: hold code at the last value, increment underrun_count (saturating at 0xFFFF), and go to UNDERRUN.
REQ-026 SHALL, in UNDERRUN: hold code, and go to PRIME in the next cycle.
REQ-027 SHALL, in any state with enable=0: go to IDLE next cycle, set code=IDLE_CODE, preserve FIFO contents, and leave underrun_count unchanged.
REQ-028 SHALL, when mute=1: drive code output as 0 while internal pops and state proceed unchanged; releasing mute SHALL restore the current held sample.
REQ-029 SHALL change code only at a next_sample posedge or an IDLE transition, never mid-window during PLAY.

Reset
REQ-030 SHALL, on rst=1 at posedge, set state=IDLE, code=IDLE_CODE, pointers and fill_level to 0, and underrun_count to 0.
REQ-031 SHALL force in_ready=0 in the cycle rst is high and discard any FIFO contents, including on a mid-window reset.

Structure
REQ-032 SHALL place the FSM state encoding and the underrun counter width in the shared package dac_sched_pkg.
REQ-033 SHALL place FIFO storage and pointers in one sub-module named sample_fifo (push/pop/full/empty/count); the FSM and code register SHALL live in the top module.

Verification (bench: dac with CYCLES_PER_WINDOW=8, CODE_WIDTH=3, DEPTH=4, PRIME_LEVEL=2)
REQ-034 SHALL check: enable=1, write 1,2,3 back-to-back -> PRIME until fill=2, then PLAY; code=1,2,3 on successive windows, each update one cycle after the next_sample pulse.
REQ-035 SHALL check: write 5 samples with no pops -> in_ready=0 after the 4th, 5th not accepted, fill_level=4.
REQ-036 SHALL check: in PLAY, FIFO drained, next_sample arrives -> code holds the last value, underrun_count=1, state goes UNDERRUN then PRIME.
REQ-037 SHALL check: mute=1 during PLAY with samples 7,7 -> pwm stays 0, fill_level still decrements per window, code=7 after unmute.
REQ-038 SHALL check: rst pulse mid-window with fill=3 -> next cycle fill_level=0, code=0, state_o=0, underrun_count=0.
REQ-039 SHALL check: write and pop in the same cycle at fill=4 -> write refused, fill_level=3.

Source files
------------

// File: rtl/dac_sched_pkg.sv
// rtl/dac_sched_pkg.sv - shared FSM encoding and underrun counter definitions for dac_sample_scheduler
package dac_sched_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRIME    = 2'd1;
    localparam logic [1:0] ST_PLAY     = 2'd2;
    localparam logic [1:0] ST_UNDERRUN = 2'd3;

    localparam int UNDERRUN_W = 16;

    typedef logic [UNDERRUN_W-1:0] underrun_t;

    function automatic underrun_t sat_inc(input underrun_t v);
        return (v == {UNDERRUN_W{1'b1}}) ? v : v + underrun_t'(1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - registered-output-free sample FIFO; a push is visible at the head one cycle later
module sample_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// rtl/dac_sample_scheduler.sv - buffers producer samples and releases one DAC code per PWM window
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int CODE_WIDTH  = 10,
    parameter int DEPTH       = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int IDLE_CODE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        mute,
    input  logic [CODE_WIDTH-1:0]       in_sample,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        next_sample,
    output logic [CODE_WIDTH-1:0]       code,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic [UNDERRUN_W-1:0]       underrun_count,
    output logic [1:0]                  state_o
);
    localparam int                    FW     = $clog2(DEPTH) + 1;
    localparam logic [CODE_WIDTH-1:0] IDLE_C = CODE_WIDTH'(IDLE_CODE);

    logic [1:0]            state_q, state_d;
    logic [CODE_WIDTH-1:0] code_q, code_d;
    underrun_t             underrun_q, underrun_d;

    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [CODE_WIDTH-1:0] head;
    logic [FW-1:0]         count;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;

    sample_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_sample),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            code_d  = IDLE_C;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    code_d  = IDLE_C;
                    state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    if (count >= FW'(PRIME_LEVEL)) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // Code only moves on the window boundary so each PWM window is stable.
                    if (next_sample) begin
                        if (!empty) begin
                            pop    = 1'b1;
                            code_d = head;
                        end else begin
                            underrun_d = sat_inc(underrun_q);
                            state_d    = ST_UNDERRUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_PRIME;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            code_q     <= IDLE_C;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            underrun_q <= underrun_d;
        end
    end

    assign code           = mute ? '0 : code_q;
    assign fill_level     = count;
    assign underrun_count = underrun_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb/tb_dac_sample_scheduler.sv - scoreboard bench for dac_sample_scheduler
module tb_dac_sample_scheduler;
    localparam int CW   = 3;
    localparam int DEP  = 4;
    localparam int PRL  = 2;
    localparam int CPW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          mute;
    logic [CW-1:0] in_sample;
    logic          in_valid;
    logic          in_ready;
    logic          next_sample;
    logic [CW-1:0] code;
    logic [2:0]    fill_level;
    logic [15:0]   underrun_count;
    logic [1:0]    state_o;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] held;

    dac_sample_scheduler #(
        .CODE_WIDTH  (CW),
        .DEPTH       (DEP),
        .PRIME_LEVEL (PRL),
        .IDLE_CODE   (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .mute           (mute),
        .in_sample      (in_sample),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .next_sample    (next_sample),
        .code           (code),
        .fill_level     (fill_level),
        .underrun_count (underrun_count),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [CW-1:0] v);
        in_sample = v;
        in_valid  = 1'b1;
        #0;
        if (in_ready) exp_q.push_back(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic window();
        for (int i = 0; i < CPW; i++) begin
            next_sample = (i == CPW - 1);
            if (i == CPW / 2) chk("mid_window_code", 32'(code), 32'(mute ? 3'd0 : held));
            tick();
        end
        next_sample = 1'b0;
        if (exp_q.size() != 0) begin
            held = exp_q.pop_front();
            chk("play_code", 32'(code), 32'(mute ? 3'd0 : held));
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mute = 1'b0; in_sample = '0;
        in_valid = 1'b0; next_sample = 1'b0; held = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_underrun", 32'(underrun_count), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready), 1);

        // priming and in-order playback
        enable = 1'b1;
        write(3'd1);
        chk("prime_state_1", 32'(state_o), 1);
        write(3'd2);
        chk("prime_state_2", 32'(state_o), 1);
        chk("prime_fill", 32'(fill_level), 2);
        write(3'd3);
        chk("play_state", 32'(state_o), 2);
        chk("play_code_before", 32'(code), 0);
        window();
        chk("fill_after_w1", 32'(fill_level), 2);
        window();
        window();
        chk("fill_after_w3", 32'(fill_level), 0);

        // underrun on empty FIFO
        window();
        chk("underrun_code_hold", 32'(code), 3);
        chk("underrun_count", 32'(underrun_count), 1);
        chk("underrun_state", 32'(state_o), 3);
        tick();
        chk("underrun_to_prime", 32'(state_o), 1);
        chk("prime_code_hold", 32'(code), 3);

        // mute keeps consumption going
        write(3'd7);
        write(3'd7);
        tick();
        chk("mute_play_state", 32'(state_o), 2);
        mute = 1'b1;
        window();
        chk("mute_fill_1", 32'(fill_level), 1);
        window();
        chk("mute_fill_0", 32'(fill_level), 0);
        mute = 1'b0;
        #1;
        chk("unmute_code", 32'(code), 7);

        // disable returns to idle, counter kept
        enable = 1'b0;
        tick();
        held = '0;
        chk("disable_state", 32'(state_o), 0);
        chk("disable_code", 32'(code), 0);
        chk("disable_underrun", 32'(underrun_count), 1);

        // fill to full while idle
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) chk("full_in_ready", 32'(in_ready), 0);
            write(3'(i));
        end
        chk("full_fill", 32'(fill_level), 4);
        chk("full_queue", 32'(exp_q.size()), 4);

        // simultaneous write and pop at full
        enable = 1'b1;
        tick();
        tick();
        chk("full_play_state", 32'(state_o), 2);
        in_sample = 3'd5; in_valid = 1'b1; next_sample = 1'b1;
        #0;
        if (in_ready) exp_q.push_back(3'd5);
        tick();
        in_valid = 1'b0; next_sample = 1'b0;
        held = exp_q.pop_front();
        chk("same_cycle_fill", 32'(fill_level), 3);
        chk("same_cycle_code", 32'(code), 32'(held));

        // reset mid-window
        tick(); tick(); tick();
        rst = 1'b1; enable = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        held = '0;
        chk("midrst_fill", 32'(fill_level), 0);
        chk("midrst_code", 32'(code), 0);
        chk("midrst_state", 32'(state_o), 0);
        chk("midrst_underrun", 32'(underrun_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
